// File: rtl/ram4k_arbiter_if.sv
// Requester port of the shared ram4k: request/ack handshake plus
// registered read-data return.
interface ram4k_arbiter_if #(
   parameter int ADR_W  = 12,
   parameter int DATA_W = 16
);
   logic              req;
   logic              we;
   logic [ADR_W-1:0]  adr;
   logic [DATA_W-1:0] wdata;
   logic              ack;
   logic              rvalid;
   logic [DATA_W-1:0] rdata;

   modport master (
      output req, we, adr, wdata,
      input  ack, rvalid, rdata
   );

   modport slave (
      input  req, we, adr, wdata,
      output ack, rvalid, rdata
   );
endinterface

// File: rtl/ram4k_arbiter.sv
// Round-robin arbiter sharing one ram4k between requesters A and B.
// Define RAM_CLEAR_EN to add the post-reset / on-demand zero-fill sequencer.
module ram4k_arbiter #(
   parameter int                ADR_W     = 12,
   parameter int                DATA_W    = 16,
   parameter logic [DATA_W-1:0] CLR_VALUE = '0
) (
   input  logic              clk,
   input  logic              reset,
   ram4k_arbiter_if.slave    a,
   ram4k_arbiter_if.slave    b,
   output logic [ADR_W-1:0]  ram_adr,
   output logic [DATA_W-1:0] ram_data,
   output logic              ram_load,
   input  logic [DATA_W-1:0] ram_out,
`ifdef RAM_CLEAR_EN
   input  logic              clr_start,
`endif
   output logic              busy
);

   logic             arb_en;
   logic             clr_own;
   logic [ADR_W-1:0] clr_cnt;
   logic             prio_b;
   logic             win_a;
   logic             win_b;
   logic             gnt_a;
   logic             gnt_b;

`ifdef RAM_CLEAR_EN
   typedef enum logic {
      IDLE,
      CLEAR
   } state_t;

   state_t           state;
   state_t           state_nx;
   logic [ADR_W-1:0] clr_cnt_nx;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= CLEAR;
         clr_cnt <= '0;
      end else begin
         state   <= state_nx;
         clr_cnt <= clr_cnt_nx;
      end
   end

   // The counter wraps to 0 on its own after the last word.
   always_comb begin
      state_nx   = state;
      clr_cnt_nx = clr_cnt;
      arb_en     = 1'b0;
      clr_own    = 1'b0;
      unique case (state)
         IDLE: begin
            if (clr_start)
               state_nx = CLEAR;
            else
               arb_en = 1'b1;
         end
         CLEAR: begin
            clr_own    = 1'b1;
            clr_cnt_nx = clr_cnt + 1'b1;
            if (clr_cnt == '1)
               state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   assign busy = (state == CLEAR);
`else
   assign arb_en  = 1'b1;
   assign clr_own = 1'b0;
   assign clr_cnt = '0;
   assign busy    = 1'b0;
`endif

   // Winner terms are mutually exclusive by construction.
   assign win_a = a.req & (~b.req | ~prio_b);
   assign win_b = b.req & (~a.req |  prio_b);

   always_comb begin
      gnt_a = 1'b0;
      gnt_b = 1'b0;
      if (arb_en) begin
         unique case (1'b1)
            win_a:   gnt_a = 1'b1;
            win_b:   gnt_b = 1'b1;
            default: ;
         endcase
      end
   end

   assign a.ack = gnt_a;
   assign b.ack = gnt_b;

   always_comb begin
      ram_adr  = '0;
      ram_data = '0;
      ram_load = 1'b0;
      unique case (1'b1)
         clr_own: begin
            ram_adr  = clr_cnt;
            ram_data = CLR_VALUE;
            ram_load = 1'b1;
         end
         gnt_a: begin
            ram_adr  = a.adr;
            ram_data = a.wdata;
            ram_load = a.we;
         end
         gnt_b: begin
            ram_adr  = b.adr;
            ram_data = b.wdata;
            ram_load = b.we;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         prio_b <= 1'b0;
      else if (gnt_a)
         prio_b <= 1'b1;
      else if (gnt_b)
         prio_b <= 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         a.rvalid <= 1'b0;
         a.rdata  <= '0;
      end else begin
         a.rvalid <= gnt_a & ~a.we;
         if (gnt_a & ~a.we)
            a.rdata <= ram_out;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         b.rvalid <= 1'b0;
         b.rdata  <= '0;
      end else begin
         b.rvalid <= gnt_b & ~b.we;
         if (gnt_b & ~b.we)
            b.rdata <= ram_out;
      end
   end

endmodule

// File: tb/tb_ram4k_arbiter.sv
// Directed bench for ram4k_arbiter with a behavioural ram4k model;
// clear-sequencer sequences run only when RAM_CLEAR_EN is defined.
module tb_ram4k_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [11:0] ram_adr;
   logic [15:0] ram_data;
   logic [15:0] ram_out;
   logic        ram_load;
   logic        busy;
`ifdef RAM_CLEAR_EN
   logic        clr_start;
`endif

   ram4k_arbiter_if a_if ();
   ram4k_arbiter_if b_if ();

   always #5 clk = ~clk;

   ram4k_arbiter dut (
      .clk      (clk),
      .reset    (reset),
      .a        (a_if.slave),
      .b        (b_if.slave),
      .ram_adr  (ram_adr),
      .ram_data (ram_data),
      .ram_load (ram_load),
      .ram_out  (ram_out),
`ifdef RAM_CLEAR_EN
      .clr_start(clr_start),
`endif
      .busy     (busy)
   );

   logic [15:0] mem [4096];

   initial begin
      for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
   end

   always @(posedge clk) if (ram_load) mem[ram_adr] <= ram_data;
   assign ram_out = mem[ram_adr];

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic ar, input logic aw, input logic [11:0] aa,
                        input logic [15:0] ad, input logic br, input logic bw,
                        input logic [11:0] ba, input logic [15:0] bd);
      a_if.req = ar; a_if.we = aw; a_if.adr = aa; a_if.wdata = ad;
      b_if.req = br; b_if.we = bw; b_if.adr = ba; b_if.wdata = bd;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

`ifdef RAM_CLEAR_EN
   task automatic wait_clear(input string name);
      int n;
      logic acked;
      n = 0;
      acked = 1'b0;
      while (busy && n < 5000) begin
         if (a_if.ack || b_if.ack) acked = 1'b1;
         n++;
         @(negedge clk);
      end
      chk({name, "_len"}, n, 4096);
      chk({name, "_noack"}, acked, 0);
   endtask
`endif

   typedef struct {
      logic        ar, aw;
      logic [11:0] aadr;
      logic [15:0] ad;
      logic        br, bw;
      logic [11:0] badr;
      logic [15:0] bd;
      logic        eaa, eba, eld;
      logic [11:0] eadr;
      logic        earv;
      logic [15:0] eard;
      logic        ebrv;
      logic [15:0] ebrd;
   } vec_t;

   vec_t v [13];

   initial begin
      v[0]  = '{1,1,12'h005,16'hBEEF, 0,0,12'h000,16'h0000, 1,0,1,12'h005, 0,16'h0000, 0,16'h0000};
      v[1]  = '{1,0,12'h005,16'h0000, 0,0,12'h000,16'h0000, 1,0,0,12'h005, 1,16'hBEEF, 0,16'h0000};
      v[2]  = '{0,0,12'h000,16'h0000, 0,0,12'h000,16'h0000, 0,0,0,12'h000, 0,16'hBEEF, 0,16'h0000};
      v[3]  = '{0,0,12'h000,16'h0000, 1,1,12'hFFF,16'h1234, 0,1,1,12'hFFF, 0,16'hBEEF, 0,16'h0000};
      v[4]  = '{1,0,12'hFFF,16'h0000, 0,0,12'h000,16'h0000, 1,0,0,12'hFFF, 1,16'h1234, 0,16'h0000};
      v[5]  = '{1,1,12'h000,16'h5A5A, 0,0,12'h000,16'h0000, 1,0,1,12'h000, 0,16'h1234, 0,16'h0000};
      v[6]  = '{1,0,12'h000,16'h0000, 0,0,12'h000,16'h0000, 1,0,0,12'h000, 1,16'h5A5A, 0,16'h0000};
      v[7]  = '{1,0,12'h005,16'h0000, 1,0,12'hFFF,16'h0000, 0,1,0,12'hFFF, 0,16'h5A5A, 1,16'h1234};
      v[8]  = '{1,0,12'h005,16'h0000, 1,0,12'hFFF,16'h0000, 1,0,0,12'h005, 1,16'hBEEF, 0,16'h1234};
      v[9]  = '{1,0,12'h005,16'h0000, 1,0,12'hFFF,16'h0000, 0,1,0,12'hFFF, 0,16'hBEEF, 1,16'h1234};
      v[10] = '{1,0,12'h123,16'h0000, 1,1,12'h123,16'h7777, 1,0,0,12'h123, 1,16'h0000, 0,16'h1234};
      v[11] = '{1,0,12'h123,16'h0000, 1,1,12'h123,16'h7777, 0,1,1,12'h123, 0,16'h0000, 0,16'h1234};
      v[12] = '{1,0,12'h123,16'h0000, 0,0,12'h000,16'h0000, 1,0,0,12'h123, 1,16'h7777, 0,16'h1234};

      drive(0,0,0,0,0,0,0,0);
`ifdef RAM_CLEAR_EN
      clr_start = 1'b0;
`endif
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("rst_a_rvalid", a_if.rvalid, 0);
      chk("rst_b_rvalid", b_if.rvalid, 0);
      chk("rst_a_rdata", a_if.rdata, 0);
      chk("rst_b_rdata", b_if.rdata, 0);
`ifdef RAM_CLEAR_EN
      chk("rst_busy", busy, 1);
      reset = 1'b0;
      wait_clear("init_clear");
`else
      chk("rst_busy", busy, 0);
      reset = 1'b0;
`endif

      for (int i = 0; i < 13; i++) begin
         drive(v[i].ar, v[i].aw, v[i].aadr, v[i].ad,
               v[i].br, v[i].bw, v[i].badr, v[i].bd);
         #1;
         chk($sformatf("v%0d_a_ack", i), a_if.ack, v[i].eaa);
         chk($sformatf("v%0d_b_ack", i), b_if.ack, v[i].eba);
         chk($sformatf("v%0d_load", i), ram_load, v[i].eld);
         chk($sformatf("v%0d_adr", i), ram_adr, v[i].eadr);
         @(posedge clk);
         #1;
         chk($sformatf("v%0d_a_rvalid", i), a_if.rvalid, v[i].earv);
         chk($sformatf("v%0d_a_rdata", i), a_if.rdata, v[i].eard);
         chk($sformatf("v%0d_b_rvalid", i), b_if.rvalid, v[i].ebrv);
         chk($sformatf("v%0d_b_rdata", i), b_if.rdata, v[i].ebrd);
         @(negedge clk);
      end

`ifdef RAM_CLEAR_EN
      drive(1,1,12'h200,16'hAAAA,0,0,0,0);
      @(negedge clk);
      drive(1,0,12'h200,16'h0000,0,0,0,0);
      clr_start = 1'b1;
      #1;
      chk("clr_start_noack", a_if.ack, 0);
      chk("clr_prefill", mem[12'h200], 16'hAAAA);
      @(negedge clk);
      clr_start = 1'b0;
      chk("clr_busy", busy, 1);
      wait_clear("cmd_clear");
      chk("post_clr_ack", a_if.ack, 1);
      @(posedge clk);
      #1;
      chk("post_clr_rvalid", a_if.rvalid, 1);
      chk("post_clr_rdata", a_if.rdata, 16'h0000);
      @(negedge clk);
      drive(0,0,0,0,0,0,0,0);

      do_reset();
      repeat (100) @(negedge clk);
      chk("mid_clr_busy", busy, 1);
      do_reset();
      chk("restart_busy", busy, 1);
      wait_clear("restart_clear");
`endif

      do_reset();
`ifdef RAM_CLEAR_EN
      wait_clear("alt_clear");
`endif
      drive(1,0,12'h005,0,1,0,12'hFFF,0);
      for (int i = 0; i < 6; i++) begin
         #1;
         chk($sformatf("alt%0d_a_ack", i), a_if.ack, (i % 2) == 0);
         chk($sformatf("alt%0d_b_ack", i), b_if.ack, (i % 2) == 1);
         chk($sformatf("alt%0d_both", i), a_if.ack & b_if.ack, 0);
         @(posedge clk);
         #1;
         chk($sformatf("alt%0d_a_rv", i), a_if.rvalid, (i % 2) == 0);
         chk($sformatf("alt%0d_b_rv", i), b_if.rvalid, (i % 2) == 1);
         @(negedge clk);
      end

      drive(1,0,12'h005,0,0,0,0,0);
      #1;
      chk("rstrd_ack", a_if.ack, 1);
      #2;
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("rstrd_rvalid", a_if.rvalid, 0);
      chk("rstrd_rdata", a_if.rdata, 0);
      @(negedge clk);
      reset = 1'b0;
`ifdef RAM_CLEAR_EN
      wait_clear("rstrd_clear");
`endif
      drive(1,0,12'h005,0,1,0,12'hFFF,0);
      #1;
      chk("rstrd_prio_a", a_if.ack, 1);
      chk("rstrd_prio_b", b_if.ack, 0);
      @(negedge clk);
      drive(0,0,0,0,0,0,0,0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
